dither_pipe: RTL and testbench

DITHER_PIPE -- requirements
Module: dither_pipe

---
 rtl/dither_pipe.sv | 178 +++++++++++++++++
 tb/tb_dither_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_pipe.sv
// dither_pipe: two-stage colour reducer. Each pixel receives an optional
// ordered-dither or rounding offset, then is clamped to the input range and
// truncated to OUT_W bits per channel. Valid/ready handshakes sit on both
// sides of the pipe, and a sideband tag travels with every pixel.
module dither_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 5,
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             i_nrst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_r,
  input  logic [IN_W-1:0]  i_g,
  input  logic [IN_W-1:0]  i_b,
  input  logic [1:0]       i_x,
  input  logic [1:0]       i_y,
  input  logic [1:0]       i_mode,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_r,
  output logic [OUT_W-1:0] o_g,
  output logic [OUT_W-1:0] o_b,
  output logic [TAG_W-1:0] o_tag
);

  // The sum is two bits wider than a channel. This leaves room for a negative
  // result (after a dither offset is subtracted) and for an overflow past full
  // scale.
  localparam int SW = IN_W + 2;
  // SH scales the 3-bit dither/rounding values so that they land just below
  // the LSB of the truncated output.
  localparam int SH = IN_W - OUT_W - 3;

  localparam logic [SW-1:0] RND_OFF = {{(SW-3){1'b0}}, 3'd4} << SH;

  generate
    if ((IN_W - OUT_W) < 3 || OUT_W < 1) begin : g_param_chk
      $error("dither_pipe: need IN_W - OUT_W >= 3 and OUT_W >= 1");
    end
  endgenerate

  logic signed [2:0] w_mat;
  logic [SW-1:0]     w_off;
  logic [SW-1:0]     w_sum_r;
  logic [SW-1:0]     w_sum_g;
  logic [SW-1:0]     w_sum_b;
  logic              w_s2_adv;
  logic              w_s1_adv;

  logic              r_rdy_en;
  logic              r_s1_v;
  logic [SW-1:0]     r_s1_r;
  logic [SW-1:0]     r_s1_g;
  logic [SW-1:0]     r_s1_b;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s2_v;
  logic [OUT_W-1:0]  r_s2_r;
  logic [OUT_W-1:0]  r_s2_g;
  logic [OUT_W-1:0]  r_s2_b;
  logic [TAG_W-1:0]  r_s2_tag;

  // Clamp the sum to [0, 2^IN_W-1], then keep the top OUT_W bits. The sum
  // cannot reach 2^(IN_W+1), so checking bit IN_W is enough to detect
  // overflow.
  function automatic logic [OUT_W-1:0] clamp_trunc(input logic [SW-1:0] s);
    logic [IN_W-1:0] c;
    if (s[SW-1])
      c = '0;
    else if (s[SW-2])
      c = '1;
    else
      c = s[IN_W-1:0];
    return c[IN_W-1 -: OUT_W];
  endfunction

  // Look up the 4x4 ordered-dither matrix, indexed by screen coordinate LSBs.
  always_comb begin
    w_mat = 3'sd0;
    case ({i_y, i_x})
      4'h0: w_mat = -3'sd4;
      4'h1: w_mat =  3'sd0;
      4'h2: w_mat = -3'sd3;
      4'h3: w_mat =  3'sd1;
      4'h4: w_mat =  3'sd2;
      4'h5: w_mat = -3'sd2;
      4'h6: w_mat =  3'sd3;
      4'h7: w_mat = -3'sd1;
      4'h8: w_mat = -3'sd3;
      4'h9: w_mat =  3'sd1;
      4'hA: w_mat = -3'sd4;
      4'hB: w_mat =  3'sd0;
      4'hC: w_mat =  3'sd3;
      4'hD: w_mat = -3'sd1;
      4'hE: w_mat =  3'sd2;
      4'hF: w_mat = -3'sd2;
      default: w_mat = 3'sd0;
    endcase
  end

  // Choose the per-pixel offset: dither value, rounding half-LSB, or none.
  // Mode 3 behaves like mode 0 (no offset).
  always_comb begin
    w_off = '0;
    case (i_mode)
      2'd1:    w_off = {{(SW-3){w_mat[2]}}, w_mat} << SH;
      2'd2:    w_off = RND_OFF;
      default: w_off = '0;
    endcase
  end

  assign w_sum_r = {2'b00, i_r} + w_off;
  assign w_sum_g = {2'b00, i_g} + w_off;
  assign w_sum_b = {2'b00, i_b} + w_off;

  // A stage moves forward when it is empty or when the stage after it drains.
  // o_ready stays low until the first edge after reset, so the input side
  // only opens once the pipe is known to be clean.
  assign w_s2_adv = !r_s2_v || i_ready;
  assign w_s1_adv = r_rdy_en && (!r_s1_v || w_s2_adv);
  assign o_ready  = w_s1_adv;

  // Input-side enable: set on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst)
      r_rdy_en <= 1'b0;
    else
      r_rdy_en <= 1'b1;
  end

  // Stage 1: register the offset sums and the tag on an input transfer.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_s1_v   <= 1'b0;
      r_s1_r   <= '0;
      r_s1_g   <= '0;
      r_s1_b   <= '0;
      r_s1_tag <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= i_valid;
      if (i_valid) begin
        r_s1_r   <= w_sum_r;
        r_s1_g   <= w_sum_g;
        r_s1_b   <= w_sum_b;
        r_s1_tag <= i_tag;
      end
    end
  end

  // Stage 2: register the clamped, truncated result. While the output is
  // stalled, the stage holds its value.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_s2_v   <= 1'b0;
      r_s2_r   <= '0;
      r_s2_g   <= '0;
      r_s2_b   <= '0;
      r_s2_tag <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_r   <= clamp_trunc(r_s1_r);
        r_s2_g   <= clamp_trunc(r_s1_g);
        r_s2_b   <= clamp_trunc(r_s1_b);
        r_s2_tag <= r_s1_tag;
      end
    end
  end

  assign o_valid = r_s2_v;
  assign o_r     = r_s2_r;
  assign o_g     = r_s2_g;
  assign o_b     = r_s2_b;
  assign o_tag   = r_s2_tag;

endmodule

// File: tb/tb_dither_pipe.sv
// Bench for dither_pipe: directed vectors, stall/backpressure, mid-flight
// reset and a randomised run against a scoreboard built from a behavioural
// reference model.
module tb_dither_pipe;
  localparam int IN_W  = 8;
  localparam int OUT_W = 5;
  localparam int TAG_W = 1;
  localparam int SH    = IN_W - OUT_W - 3;
  localparam int PXW   = TAG_W + 3*OUT_W;

  logic             clk;
  logic             i_nrst;
  logic             i_valid;
  logic             o_ready;
  logic [IN_W-1:0]  i_r, i_g, i_b;
  logic [1:0]       i_x, i_y, i_mode;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [OUT_W-1:0] o_r, o_g, o_b;
  logic [TAG_W-1:0] o_tag;

  dither_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .i_nrst(i_nrst), .i_valid(i_valid), .o_ready(o_ready),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_x(i_x), .i_y(i_y), .i_mode(i_mode),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_tag(o_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;
  logic accepted;
  logic [PXW-1:0] sb_q[$];
  int mat[16] = '{-4, 0, -3, 1, 2, -2, 3, -1, -3, 1, -4, 0, 3, -1, 2, -2};

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [OUT_W-1:0] ref_ch(int v, int off);
    int s;
    s = v + off;
    if (s < 0) s = 0;
    if (s > (1 << IN_W) - 1) s = (1 << IN_W) - 1;
    return OUT_W'(s >> (IN_W - OUT_W));
  endfunction

  function automatic logic [PXW-1:0] ref_px(int mode, int x, int y, int r, int g, int b, int tag);
    int off;
    if (mode == 1)      off = mat[y*4 + x] * (1 << SH);
    else if (mode == 2) off = 4 << SH;
    else                off = 0;
    return {TAG_W'(tag), ref_ch(r, off), ref_ch(g, off), ref_ch(b, off)};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_px(input int mode, input int x, input int y, input int r, input int g,
                        input int b, input int tag);
    i_valid = 1'b1;
    i_mode  = 2'(mode);
    i_x     = 2'(x);
    i_y     = 2'(y);
    i_r     = IN_W'(r);
    i_g     = IN_W'(g);
    i_b     = IN_W'(b);
    i_tag   = TAG_W'(tag);
  endtask

  // Called at a falling edge with the inputs already driven: record the
  // transfers that the next rising edge will perform, then move to the
  // following falling edge.
  task automatic cycle();
    logic [PXW-1:0] exp;
    #1;
    if (o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", {o_tag, o_r, o_g, o_b}, 32'hFFFF_FFFF);
      end else begin
        exp = sb_q.pop_front();
        check("pixel", {o_tag, o_r, o_g, o_b}, exp);
        n_out++;
      end
    end
    accepted = i_valid && o_ready;
    if (accepted) begin
      sb_q.push_back(ref_px(i_mode, i_x, i_y, i_r, i_g, i_b, i_tag));
      n_in++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int mode, input int x, input int y, input int r, input int g,
                      input int b, input int tag);
    int k;
    set_px(mode, x, y, r, g, b, tag);
    k = 0;
    accepted = 1'b0;
    while (!accepted && k < 50) begin
      cycle();
      k++;
    end
    if (!accepted) check("send_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic directed(input string name, input int mode, input int x, input int y,
                          input int r, input int g, input int b,
                          input int er, input int eg, input int eb);
    int k;
    send(mode, x, y, r, g, b, 1);
    k = 0;
    #1;
    while (!o_valid && k < 10) begin
      cycle();
      #1;
      k++;
    end
    check({name, "_valid"}, o_valid, 1);
    check(name, {o_r, o_g, o_b}, {OUT_W'(er), OUT_W'(eg), OUT_W'(eb)});
    cycle();
  endtask

  int px_r[4] = '{10, 100, 200, 250};
  int px_t[4] = '{0, 1, 1, 0};

  initial begin
    int idx, k, acc_cnt;
    i_nrst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_r = '0; i_g = '0; i_b = '0; i_x = '0; i_y = '0; i_mode = '0; i_tag = '0;
    accepted = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_data", {o_tag, o_r, o_g, o_b}, 0);
    i_nrst = 1'b1;
    #1 check("rel_ready_pre", o_ready, 0);
    @(posedge clk); @(negedge clk);
    check("rel_ready_post", o_ready, 1);

    // Latency: a pixel accepted at edge A is valid after edge B.
    set_px(1, 0, 0, 0, 128, 255, 1);
    cycle();
    check("lat_accept", accepted, 1);
    i_valid = 1'b0;
    #1 check("lat_cycle1", o_valid, 0);
    cycle();
    check("lat_cycle2", o_valid, 1);
    check("dither_00", {o_r, o_g, o_b}, {5'd0, 5'd15, 5'd31});
    cycle();

    directed("dither_23", 1, 2, 3, 254, 6, 7, 31, 1, 1);
    directed("dither_31", 1, 3, 1, 8, 16, 0, 0, 1, 0);
    directed("trunc", 0, 1, 2, 7, 8, 255, 0, 1, 31);
    directed("round", 2, 0, 0, 3, 4, 253, 0, 1, 31);
    directed("mode3", 3, 0, 0, 7, 8, 255, 0, 1, 31);

    // Backpressure: four pixels offered while the output is stalled.
    i_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      set_px(0, 0, 0, px_r[idx], px_r[idx], px_r[idx], px_t[idx]);
      cycle();
      if (accepted) idx++;
      if (o_valid && sb_q.size() > 0) check("hold", {o_tag, o_r, o_g, o_b}, sb_q[0]);
    end
    check("stall_accepted", idx, 2);
    #1 check("stall_ready", o_ready, 0);
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) set_px(0, 0, 0, px_r[idx], px_r[idx], px_r[idx], px_t[idx]);
      else i_valid = 1'b0;
      #1 check("stream_valid", o_valid, 1);
      cycle();
      if (accepted) idx++;
    end
    i_valid = 1'b0;
    check("stream_drained", sb_q.size(), 0);
    check("stream_all_in", idx, 4);

    // Reset while two pixels are in flight.
    i_ready = 1'b0;
    set_px(1, 1, 1, 50, 60, 70, 1);
    cycle();
    set_px(2, 2, 2, 80, 90, 100, 0);
    cycle();
    i_valid = 1'b0;
    #1 check("pre_rst_valid", o_valid, 1);
    #1 i_nrst = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_ready", o_ready, 0);
    check("mid_rst_data", {o_tag, o_r, o_g, o_b}, 0);
    sb_q.delete();
    @(negedge clk);
    i_nrst = 1'b1;
    i_ready = 1'b1;
    #1 check("rel2_ready_pre", o_ready, 0);
    @(posedge clk); @(negedge clk);
    check("rel2_ready_post", o_ready, 1);
    for (int c = 0; c < 3; c++) begin
      #1 check("no_ghost", o_valid, 0);
      cycle();
    end
    directed("post_rst", 2, 0, 0, 3, 4, 253, 0, 1, 31);

    // Random traffic with random output stalls.
    n_in = 0; n_out = 0; acc_cnt = 0; k = 0;
    while (acc_cnt < 1000 && k < 20000) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0) begin
        set_px($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 1));
      end else begin
        i_valid = 1'b0;
      end
      cycle();
      if (accepted) acc_cnt++;
      k++;
    end
    check("rand_accepted", acc_cnt, 1000);
    i_valid = 1'b0;
    i_ready = 1'b1;
    k = 0;
    while (sb_q.size() > 0 && k < 20) begin
      cycle();
      k++;
    end
    check("rand_drained", sb_q.size(), 0);
    check("rand_count", n_out, n_in);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
